// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: shares one registered-output ALU among NREQ requesters.
// Latency: accept at T, rsp_valid at T+LAT+1, next accept no earlier than T+LAT+2.
// Backpressure: req_ready is low outside IDLE, so a requester holds req_valid until it is granted.
//
// Ports:
//   clk, reset          posedge clock, synchronous active-high reset
//   req_valid/a/b/op    packed per-requester request (requester i at [i*W +: W])
//   req_ready           one-hot combinational grant, asserted only in IDLE
//   alu_a/b/op          registered operands/opcode driven into the ALU
//   alu_result/flags    registered ALU outputs, sampled LAT cycles after load
//   rsp_valid           one-hot, one-cycle response strobe to the granted requester
//   rsp_result/flags    captured result, meaningful while rsp_valid is high
//   busy                high whenever an operation is in flight
//
// Build option: define ALU_FIXED_PRIO_EN to grant the lowest asserted index
// instead of round-robin (the rotation pointer is then removed).
module alu_rr_scheduler #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int OPW   = 4,
  parameter int LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*OPW-1:0]   req_op,
  output logic [NREQ-1:0]   req_ready,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [OPW-1:0]    alu_op,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_cout,
  input  logic              alu_negative,
  input  logic              alu_zero,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_cout,
  output logic              rsp_negative,
  output logic              rsp_zero,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [IW-1:0]     r_gnt;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_alu_a;
  logic [WIDTH-1:0]  r_alu_b;
  logic [OPW-1:0]    r_alu_op;
  logic [WIDTH-1:0]  r_rsp_result;
  logic              r_rsp_cout;
  logic              r_rsp_negative;
  logic              r_rsp_zero;

  logic              w_gnt_found;
  logic [IW-1:0]     w_gnt_idx;
  logic [IW:0]       w_scan;
  logic [NREQ-1:0]   w_gnt_oh;
  logic [NREQ-1:0]   w_rsp_oh;
  logic [WIDTH-1:0]  w_sel_a;
  logic [WIDTH-1:0]  w_sel_b;
  logic [OPW-1:0]    w_sel_op;

`ifndef ALU_FIXED_PRIO_EN
  logic [IW-1:0]     r_ptr;
`endif

  // Grant search. Iterating from the far end down means the last hit
  // written is the one closest to the scan start, i.e. highest priority.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_scan      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef ALU_FIXED_PRIO_EN
      w_scan = (IW+1)'(k);
`else
      // Offset from the pointer, wrapped back into 0..NREQ-1.
      w_scan = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_scan >= (IW+1)'(NREQ)) begin
        w_scan = w_scan - (IW+1)'(NREQ);
      end
`endif
      if (req_valid[w_scan]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_scan[IW-1:0];
      end
    end
  end

  always_comb begin
    w_gnt_oh = '0;
    if (w_gnt_found) begin
      w_gnt_oh[w_gnt_idx] = 1'b1;
    end
    w_rsp_oh        = '0;
    w_rsp_oh[r_gnt] = 1'b1;
  end

  assign w_sel_a  = req_a[w_gnt_idx*WIDTH +: WIDTH];
  assign w_sel_b  = req_b[w_gnt_idx*WIDTH +: WIDTH];
  assign w_sel_op = req_op[w_gnt_idx*OPW +: OPW];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state and control outputs. req_ready is masked during reset
  // so no handshake can be claimed while the block is being cleared.
  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    rsp_valid = '0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (!reset) begin
          req_ready = w_gnt_oh;
          if (w_gnt_found) begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == CW'(1)) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = w_rsp_oh;
        w_next    = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: operand load on accept, result capture on the last WAIT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt          <= '0;
      r_cnt          <= '0;
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_alu_op       <= '0;
      r_rsp_result   <= '0;
      r_rsp_cout     <= 1'b0;
      r_rsp_negative <= 1'b0;
      r_rsp_zero     <= 1'b0;
`ifndef ALU_FIXED_PRIO_EN
      r_ptr          <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_found) begin
            r_alu_a  <= w_sel_a;
            r_alu_b  <= w_sel_b;
            r_alu_op <= w_sel_op;
            r_gnt    <= w_gnt_idx;
            r_cnt    <= CW'(LAT);
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_rsp_result   <= alu_result;
            r_rsp_cout     <= alu_cout;
            r_rsp_negative <= alu_negative;
            r_rsp_zero     <= alu_zero;
          end
        end
        S_RESP: begin
`ifndef ALU_FIXED_PRIO_EN
          // Rotate priority to the requester just after the one served.
          r_ptr <= (r_gnt == IW'(NREQ - 1)) ? '0 : r_gnt + IW'(1);
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign alu_op       = r_alu_op;
  assign rsp_result   = r_rsp_result;
  assign rsp_cout     = r_rsp_cout;
  assign rsp_negative = r_rsp_negative;
  assign rsp_zero     = r_rsp_zero;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Testbench for alu_rr_scheduler with a small negedge-registered ALU model.
// Opcodes of the model: 0 ADD, 1 SUB, 2 AND, 3 OR, others XOR.
// Directed sequence: reset, rotation over four requesters, wrap/skip, reset mid-op.
module tb_alu_rr_scheduler;
  parameter int LAT = 1;
  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int OPW   = 4;

`ifdef ALU_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*OPW-1:0]   req_op;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [OPW-1:0]        alu_op;
  logic [WIDTH-1:0]      alu_result;
  logic                  alu_cout;
  logic                  alu_negative;
  logic                  alu_zero;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_cout;
  logic                  rsp_negative;
  logic                  rsp_zero;
  logic                  busy;

  int checks   = 0;
  int failures = 0;

  // Hand-computed per-requester operands and expected ALU outcomes.
  int ea [NREQ];
  int eb [NREQ];
  int eop[NREQ];
  int er [NREQ];
  int ec [NREQ];
  int en [NREQ];
  int ez [NREQ];

  alu_rr_scheduler #(
    .WIDTH(WIDTH), .NREQ(NREQ), .OPW(OPW), .LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .req_ready(req_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_cout(rsp_cout),
    .rsp_negative(rsp_negative), .rsp_zero(rsp_zero),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU with its output register on the falling edge.
  always @(negedge clk) begin
    logic [WIDTH:0] t;
    case (alu_op)
      4'd0:    t = {1'b0, alu_a} + {1'b0, alu_b};
      4'd1:    t = {1'b0, alu_a} - {1'b0, alu_b};
      4'd2:    t = {1'b0, alu_a & alu_b};
      4'd3:    t = {1'b0, alu_a | alu_b};
      default: t = {1'b0, alu_a ^ alu_b};
    endcase
    alu_result   <= t[WIDTH-1:0];
    alu_cout     <= t[WIDTH];
    alu_negative <= t[WIDTH-1];
    alu_zero     <= (t[WIDTH-1:0] == '0);
  end

  function automatic logic [NREQ-1:0] oh(input int r);
    logic [NREQ-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction for requester r, starting in IDLE with inputs set.
  task automatic run_op(input int r);
    #1;
    chk("grant_ready", 32'(req_ready), 32'(oh(r)));
    @(posedge clk); #1;
    chk("wait_busy", 32'(busy), 1);
    chk("wait_ready", 32'(req_ready), 0);
    chk("alu_a", 32'(alu_a), ea[r]);
    chk("alu_b", 32'(alu_b), eb[r]);
    chk("alu_op", 32'(alu_op), eop[r]);
    for (int w = 0; w < LAT; w++) begin
      chk("rsp_early", 32'(rsp_valid), 0);
      @(posedge clk); #1;
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(oh(r)));
    chk("rsp_result", 32'(rsp_result), er[r]);
    chk("rsp_cout", 32'(rsp_cout), ec[r]);
    chk("rsp_negative", 32'(rsp_negative), en[r]);
    chk("rsp_zero", 32'(rsp_zero), ez[r]);
    chk("resp_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    chk("after_rsp_valid", 32'(rsp_valid), 0);
  endtask

  initial begin
    // req0: 7+9 -> 0 carry zero; req1: 3-5 -> E borrow neg;
    // req2: C&A -> 8 neg;        req3: 5|A -> F neg.
    ea  = '{7, 3, 12, 5};
    eb  = '{9, 5, 10, 10};
    eop = '{0, 1, 2, 3};
    er  = '{0, 14, 8, 15};
    ec  = '{1, 1, 0, 0};
    en  = '{0, 1, 1, 1};
    ez  = '{1, 0, 0, 0};

    reset     = 1'b1;
    req_valid = 4'b1111;
    req_a     = {4'h5, 4'hC, 4'h3, 4'h7};
    req_b     = {4'hA, 4'hA, 4'h5, 4'h9};
    req_op    = {4'h3, 4'h2, 4'h1, 4'h0};

    // Reset held for two cycles with all requests pending.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_alu_b", 32'(alu_b), 0);
    chk("rst_alu_op", 32'(alu_op), 0);
    chk("rst_rsp_result", 32'(rsp_result), 0);
    reset = 1'b0;

    // All four requesting: rotation 0,1,2,3 (fixed priority: always 0).
    for (int g = 0; g < NREQ; g++) begin
      run_op(FIXED ? 0 : g);
    end

    // Serve requester 2 alone, leaving the pointer at 3; then 0101 wraps to 0, then 2.
    req_valid = 4'b0100;
    run_op(2);
    req_valid = 4'b0101;
    run_op(0);
    run_op(FIXED ? 0 : 2);

    // Reset during WAIT discards the op and returns the pointer to 0.
    req_valid = 4'b0010;
    #1;
    chk("mid_grant", 32'(req_ready), 32'(oh(1)));
    @(posedge clk); #1;
    chk("mid_busy_before", 32'(busy), 1);
    reset     = 1'b1;
    req_valid = 4'b0000;
    @(posedge clk); #1;
    chk("mid_busy_after", 32'(busy), 0);
    chk("mid_rsp_valid", 32'(rsp_valid), 0);
    reset = 1'b0;
    for (int c = 0; c < LAT + 3; c++) begin
      @(posedge clk); #1;
      chk("mid_no_rsp", 32'(rsp_valid), 0);
      chk("mid_idle", 32'(busy), 0);
    end

    // Pointer back at 0: 1010 grants requester 1 (a stale pointer of 3 would grant 3).
    req_valid = 4'b1010;
    run_op(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
